// File: rtl/shift_reg_pkg.sv
// Shared types for the shift-register datapath (PISO/SIPO opcodes) and the
// frame sequencer state machine.
package shift_reg_pkg;

    // Opcode pins are {reset_n, load}; both RESET encodings clear the block.
    typedef enum logic [1:0] {
        OP_RESET_0 = 2'b00,
        OP_RESET_1 = 2'b01,
        OP_SHIFT   = 2'b10,
        OP_LOAD    = 2'b11
    } OPCODET;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_CAPTURE,
        ST_GAP
    } XFER_STATET;

endpackage

// File: rtl/piso_n.sv
// Parallel-in serial-out register, MSB first, controlled by an OPCODET pin pair.
module piso_n
    import shift_reg_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_load,
    input  logic [N-1:0] i_data_bus,
    output logic         o_serial_out
);

    OPCODET         w_op;
    logic   [N-1:0] r_shift_reg;

    assign w_op         = OPCODET'({i_reset_n, i_load});
    assign o_serial_out = r_shift_reg[N-1];

    always_ff @(posedge i_clk) begin
        case (w_op)
            OP_LOAD:  r_shift_reg <= i_data_bus;
            OP_SHIFT: r_shift_reg <= {r_shift_reg[N-2:0], 1'b0};
            default:  r_shift_reg <= '0;
        endcase
    end

endmodule

// File: rtl/sipo_n.sv
// Serial-in parallel-out register with a store register committed on LOAD.
module sipo_n
    import shift_reg_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_load,
    input  logic         i_serial_in,
    output logic [N-1:0] o_store_reg
);

    OPCODET         w_op;
    logic   [N-1:0] r_shift_reg;
    logic   [N-1:0] r_store_reg;

    assign w_op        = OPCODET'({i_reset_n, i_load});
    assign o_store_reg = r_store_reg;

    always_ff @(posedge i_clk) begin
        case (w_op)
            OP_LOAD: r_store_reg <= r_shift_reg;
            OP_SHIFT: r_shift_reg <= {r_shift_reg[N-2:0], i_serial_in};
            default: begin
                r_shift_reg <= '0;
                r_store_reg <= '0;
            end
        endcase
    end

endmodule

// File: rtl/shift_xfer_ctrl.sv
// Frame sequencer for a PISO/SIPO pair: accepts a word, shifts N bits over the
// shared line, commits the received word and reports it with overrun detection.
module shift_xfer_ctrl
    import shift_reg_pkg::*;
#(
    parameter int N   = 16,
    parameter int GAP = 1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_tx_valid,
    output logic         o_tx_ready,
    input  logic [N-1:0] i_tx_data,
    output logic         o_rx_valid,
    input  logic         i_rx_ready,
    output logic         o_rx_overrun,
    output logic [N-1:0] o_piso_data,
    output logic         o_piso_reset_n,
    output logic         o_piso_load,
    output logic         o_sipo_reset_n,
    output logic         o_sipo_load,
    output logic         o_line_en,
    output logic         o_busy
);

    localparam int CNT_W = $clog2(N);
    localparam int GAP_W = $clog2(GAP + 1);
    // The counter also times the GAP state, so it must hold GAP-1 as well.
    localparam int CW    = (CNT_W > GAP_W) ? CNT_W : GAP_W;
    localparam logic [CW-1:0] SHIFT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP > 0) ? GAP - 1 : 0);

    XFER_STATET          r_state;
    XFER_STATET          w_next_state;
    logic       [CW-1:0] r_cnt;
    logic                r_rx_valid;
    logic                r_rx_overrun;
    logic       [N-1:0]  r_piso_data;
    OPCODET              w_piso_op;
    OPCODET              w_sipo_op;
    logic                w_tx_ready;
    logic                w_line_en;
    logic                w_busy;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_INIT;
        else         r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned
        // and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            ST_INIT:    w_next_state = ST_IDLE;
            ST_IDLE:    if (i_tx_valid) w_next_state = ST_LOAD;
            ST_LOAD:    w_next_state = ST_SHIFT;
            ST_SHIFT:   if (r_cnt == '0) w_next_state = ST_CAPTURE;
            ST_CAPTURE: w_next_state = (GAP > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:     if (r_cnt == '0) w_next_state = ST_IDLE;
            default:    w_next_state = ST_INIT;
        endcase
    end

    always_comb begin
        w_piso_op  = OP_SHIFT;
        w_sipo_op  = OP_SHIFT;
        w_tx_ready = 1'b0;
        w_line_en  = 1'b0;
        w_busy     = 1'b1;
        case (r_state)
            ST_INIT: begin
                w_piso_op = OP_RESET_0;
                w_sipo_op = OP_RESET_0;
            end
            ST_IDLE: begin
                w_tx_ready = 1'b1;
                w_busy     = 1'b0;
            end
            ST_LOAD:    w_piso_op = OP_LOAD;
            ST_SHIFT:   w_line_en = 1'b1;
            ST_CAPTURE: w_sipo_op = OP_LOAD;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_LOAD:    r_cnt <= SHIFT_LAST;
                ST_CAPTURE: r_cnt <= GAP_LAST;
                ST_SHIFT, ST_GAP: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // A capture edge wins over a same-edge read: the new frame stays pending.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_piso_data  <= '0;
        end else begin
            if (r_state == ST_IDLE && i_tx_valid) r_piso_data <= i_tx_data;
            if (r_state == ST_CAPTURE) begin
                r_rx_valid <= 1'b1;
                if (r_rx_valid && !i_rx_ready) r_rx_overrun <= 1'b1;
            end else if (i_rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign o_tx_ready                     = w_tx_ready;
    assign o_line_en                      = w_line_en;
    assign o_busy                         = w_busy;
    assign {o_piso_reset_n, o_piso_load}  = w_piso_op;
    assign {o_sipo_reset_n, o_sipo_load}  = w_sipo_op;
    assign o_rx_valid                     = r_rx_valid;
    assign o_rx_overrun                   = r_rx_overrun;
    assign o_piso_data                    = r_piso_data;

endmodule

// File: tb/tb_shift_xfer_ctrl.sv
// Loopback bench: controller + PISO + SIPO with serial_out tied to serial_in.
module tb_shift_xfer_ctrl;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         tx_valid = 1'b0;
    logic         rx_ready = 1'b0;
    logic [N-1:0] tx_data = '0;
    logic         tx_ready, rx_valid, rx_overrun, line_en, busy;
    logic         piso_reset_n, piso_load, sipo_reset_n, sipo_load, serial;
    logic [N-1:0] piso_data, store;

    shift_xfer_ctrl #(.N(N), .GAP(1)) u_dut (
        .i_clk(clk), .i_reset(reset), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
        .i_tx_data(tx_data), .o_rx_valid(rx_valid), .i_rx_ready(rx_ready),
        .o_rx_overrun(rx_overrun), .o_piso_data(piso_data),
        .o_piso_reset_n(piso_reset_n), .o_piso_load(piso_load),
        .o_sipo_reset_n(sipo_reset_n), .o_sipo_load(sipo_load),
        .o_line_en(line_en), .o_busy(busy)
    );

    piso_n #(.N(N)) u_piso (
        .i_clk(clk), .i_reset_n(piso_reset_n), .i_load(piso_load),
        .i_data_bus(piso_data), .o_serial_out(serial)
    );

    sipo_n #(.N(N)) u_sipo (
        .i_clk(clk), .i_reset_n(sipo_reset_n), .i_load(sipo_load),
        .i_serial_in(serial), .o_store_reg(store)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int le_cnt = 0;
    int pops = 0;
    bit sb_en = 1'b0;
    logic [N-1:0] exp_q[$];
    int acc_t[$];

    typedef struct {
        logic [N-1:0] data;
        logic [N-1:0] exp;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (line_en) le_cnt <= le_cnt + 1;
        if (!reset && tx_valid && tx_ready) acc_t.push_back(cyc);
        if (!reset && sb_en && rx_valid && rx_ready) begin
            pops <= pops + 1;
            if (exp_q.size() == 0) timeout("sb_unexpected_frame");
            else check("sb_frame", store, exp_q.pop_front());
        end
    end

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [N-1:0] w);
        int t = 0;
        tx_data  = w;
        tx_valid = 1'b1;
        while (!tx_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!tx_ready) timeout("send_ready");
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(output int k);
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (rx_valid) break;
        end
        if (!rx_valid) timeout("wait_rx");
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, le0, n_acc, p0, cnt;
        vecs[0] = '{16'h0000, 16'h0000};
        vecs[1] = '{16'h8000, 16'h8000};
        vecs[2] = '{16'h7FFF, 16'h7FFF};
        vecs[3] = '{16'hFFFF, 16'hFFFF};
        vecs[4] = '{16'h5555, 16'h5555};
        vecs[5] = '{16'hAAAA, 16'hAAAA};

        // Test 1: reset values, INIT duration, first frame latency.
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_opcodes", {piso_reset_n, piso_load, sipo_reset_n, sipo_load}, 4'b0000);
        check("rst_line_en", line_en, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_overrun", rx_overrun, 0);
        check("rst_piso_data", piso_data, 0);
        reset = 1'b0;
        check("init_tx_ready", tx_ready, 0);
        @(negedge clk);
        check("idle_tx_ready", tx_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_opcodes", {piso_reset_n, piso_load, sipo_reset_n, sipo_load}, 4'b1010);
        le0 = le_cnt;
        send(16'hA5C3);
        check("load_opcode", {piso_reset_n, piso_load, sipo_reset_n, sipo_load}, 4'b1110);
        wait_rx(k);
        check("t1_latency", k, 18);
        check("t1_line_en_cycles", le_cnt - le0, 16);
        check("t1_store", store, 16'hA5C3);
        check("t1_piso_data", piso_data, 16'hA5C3);

        // Test 2: back-to-back accepts with tx_valid held, scoreboard.
        rx_ready = 1'b1;
        @(negedge clk);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'hFFFE);
        sb_en = 1'b1;
        p0 = pops;
        n_acc = acc_t.size();
        tx_data = 16'h0001;
        tx_valid = 1'b1;
        k = 0;
        while (acc_t.size() < n_acc + 1 && k < 60) begin @(negedge clk); k++; end
        tx_data = 16'hFFFE;
        while (acc_t.size() < n_acc + 2 && k < 120) begin @(negedge clk); k++; end
        tx_valid = 1'b0;
        if (acc_t.size() < n_acc + 2) timeout("t2_accepts");
        else check("t2_spacing", acc_t[n_acc + 1] - acc_t[n_acc], 20);
        k = 0;
        while ((exp_q.size() != 0 || rx_valid) && k < 60) begin @(negedge clk); k++; end
        check("t2_pops", pops - p0, 2);
        check("t2_overrun", rx_overrun, 0);

        // Table: loopback of boundary patterns through the scoreboard.
        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i].exp);
            send(vecs[i].data);
            wait_rx(k);
            check("tbl_store", store, vecs[i].exp);
        end
        repeat (3) @(negedge clk);
        check("tbl_drained", exp_q.size(), 0);
        sb_en = 1'b0;

        // Test 3: overrun with rx_ready low across two frames.
        rx_ready = 1'b0;
        send(16'h1234);
        wait_rx(k);
        check("t3_store1", store, 16'h1234);
        check("t3_no_overrun", rx_overrun, 0);
        send(16'h5678);
        k = 0;
        while (!rx_overrun && k < 40) begin @(negedge clk); k++; end
        check("t3_overrun_edge", k, 18);
        check("t3_store2", store, 16'h5678);
        check("t3_rx_valid", rx_valid, 1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("t3_consumed", rx_valid, 0);
        check("t3_sticky", rx_overrun, 1);
        do_reset(1);
        check("t3_overrun_cleared", rx_overrun, 0);
        @(negedge clk);

        // Test 4: read pulse coinciding with the CAPTURE of frame 2.
        send(16'h1111);
        wait_rx(k);
        send(16'h2222);
        repeat (17) @(negedge clk);
        check("t4_capture_opcode", {piso_reset_n, piso_load, sipo_reset_n, sipo_load}, 4'b1011);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("t4_rx_valid", rx_valid, 1);
        check("t4_overrun", rx_overrun, 0);
        check("t4_store", store, 16'h2222);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;

        // Test 5: reset in SHIFT cycle 7 aborts the frame.
        send(16'hBEEF);
        repeat (8) @(negedge clk);
        check("t5_shifting", line_en, 1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_line_en", line_en, 0);
        check("t5_piso_reset_n", piso_reset_n, 0);
        check("t5_sipo_reset_n", sipo_reset_n, 0);
        check("t5_piso_data", piso_data, 0);
        reset = 1'b0;
        @(negedge clk);
        check("t5_ready_after_reset", tx_ready, 1);
        cnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (rx_valid) cnt++;
        end
        check("t5_no_rx_valid", cnt, 0);
        send(16'h00FF);
        wait_rx(k);
        check("t5_latency", k, 18);
        check("t5_store", store, 16'h00FF);

        // Test 6: tx activity while busy is ignored.
        rx_ready = 1'b1;
        @(negedge clk);
        n_acc = acc_t.size();
        send(16'hC0DE);
        for (int i = 0; i < 10; i++) begin
            tx_data  = N'($urandom);
            tx_valid = i[0];
            check("t6_no_ready", tx_ready, 0);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("t6_piso_data", piso_data, 16'hC0DE);
        wait_rx(k);
        check("t6_store", store, 16'hC0DE);
        check("t6_accepts", acc_t.size() - n_acc, 1);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_xfer_ctrl.md
Name: shift_xfer_ctrl

Overview:
Frame sequencer for one PISO_N/SIPO_N pair sharing a serial line (tx PISO, rx SIPO). It accepts a parallel word over a valid/ready handshake and drives the {reset_n, load} opcode pins of both datapath blocks. It runs exactly N shift cycles, commits the received word into the SIPO store register, and reports it over a valid/ready handshake with overrun detection. It sits between the host-side register interface and the shift-register datapath.

Parameters:
N, 16, frame width in bits; must match the PISO_N/SIPO_N instances; N >= 2
GAP, 1, idle cycles forced after each CAPTURE before the next accept; 0 allowed
CNT_W, $clog2(N), shift counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
tx_valid  input  1  host offers tx_data
tx_ready  output  1  controller accepts tx_data this cycle
tx_data  input  N  word to transmit, MSB first
rx_valid  output  1  SIPO store_reg holds an unread frame
rx_ready  input  1  host consumes the frame
rx_overrun  output  1  sticky: a frame was committed while rx_valid was still pending
piso_data  output  N  registered hold word, drives PISO data_bus
piso_reset_n  output  1  PISO opcode bit 1
piso_load  output  1  PISO opcode bit 0
sipo_reset_n  output  1  SIPO opcode bit 1
sipo_load  output  1  SIPO opcode bit 0
line_en  output  1  high exactly while a frame bit is on the serial line
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (sampled at a clk edge) has priority over all else. It forces state INIT, rx_valid=0, rx_overrun=0, piso_data=0 and counter=0.
- Output values while reset is high and in INIT: tx_ready=0, line_en=0, busy=1, piso_reset_n=0, piso_load=0, sipo_reset_n=0, sipo_load=0. This drives the RESET opcode to both datapath blocks.
- All opcode outputs, line_en, busy and tx_ready are Moore outputs decoded from state. rx_valid, rx_overrun and piso_data are registers.
- Opcode driven in every state not listed below: SHIFT (reset_n=1, load=0) to both blocks. The datapath never holds; free-running shifts in IDLE/GAP are harmless because store_reg changes only on LOAD.
- State INIT: lasts 1 cycle after reset deasserts, then goes to IDLE.
- State IDLE: tx_ready=1. On tx_valid&tx_ready, latch tx_data into piso_data and go to LOAD.
- State LOAD: piso_load=1, piso_reset_n=1, so the PISO loads piso_data at the end of this cycle. Load counter with N-1 and go to SHIFT.
- State SHIFT: line_en=1. Both blocks shift. Decrement the counter each cycle; after N cycles (counter==0) go to CAPTURE.
  - Serial line carries piso_data[N-1-k] in SHIFT cycle k.
- State CAPTURE: sipo_load=1, sipo_reset_n=1, so the SIPO commits shift_reg into store_reg at the end of this cycle. The PISO keeps shifting. Same edge: rx_valid<=1.
  - If rx_valid was 1 and rx_ready was 0 in that cycle, rx_overrun<=1.
  - Next state is GAP if GAP>0, else IDLE.
- State GAP: lasts GAP cycles, then goes to IDLE.
- rx handshake: rx_valid clears on the edge where rx_valid&rx_ready=1, unless that edge is also a CAPTURE edge. In that case rx_valid stays 1 and no overrun is flagged.
- On overrun the older frame is lost: store_reg is overwritten by the SIPO and rx_valid stays 1. rx_overrun clears only on reset.
- Latency: accept edge e0 → PISO loaded at e0+1 → line_en high in cycles e0+1..e0+17 (N=16) → store_reg updates and rx_valid rises at e0+N+2.
- Accept-to-accept spacing: N+3+GAP cycles (20 at defaults).
- tx_valid and tx_data are ignored outside IDLE; piso_data is stable from accept until the next accept.
- Reset mid-frame: the frame is aborted, no rx_valid is produced, and the next accept is possible 2 cycles after reset deasserts.

Decomposition:
- Shared package shift_reg_pkg holds:
  - opcode enum OPCODET (SHIFT=2'b10, LOAD=2'b11, RESET_0=2'b00, RESET_1=2'b01), imported by PISO_N/SIPO_N too;
  - controller state enum XFER_STATET (INIT, IDLE, LOAD, SHIFT, CAPTURE, GAP).
- Drive the opcode pins as OPCODET values.
- No sub-module: the counter and FSM stay in one block.
- Bench wraps shift_xfer_ctrl + PISO_N + SIPO_N with the PISO serial_out looped to the SIPO serial_in.

Test Plan:
1. N=16, GAP=1; reset 2 cycles, send 0xA5C3 in loopback → tx_ready rises 1 cycle after reset release; line_en high exactly 16 cycles; store_reg=0xA5C3 and rx_valid=1 at accept+18.
2. tx_valid held high with 0x0001 then 0xFFFE, rx_ready=1 → accepts 20 cycles apart; rx frames 0x0001, 0xFFFE in order; rx_overrun=0.
3. rx_ready=0 across two frames 0x1234, 0x5678 → rx_overrun=1 at the second capture edge; store_reg=0x5678; rx_valid stays 1.
4. rx_ready pulsed in the same cycle as CAPTURE of frame 2 → rx_valid stays 1, rx_overrun=0.
5. Reset asserted in SHIFT cycle 7 of 0xBEEF → the next cycle shows line_en=0, piso_reset_n=0, sipo_reset_n=0, piso_data=0; no rx_valid; a new frame 0x00FF completes correctly.
6. tx_data toggled and tx_valid pulsed while busy → no accept; piso_data unchanged; the received frame equals the originally accepted word.
